data_ram: RTL and testbench

//  Single-port synchronous 64x32 data RAM feeding the 5x5 matrix-inverse engine.

---
 rtl/data_ram.sv | 44 ++++
 tb/tb_data_ram.sv | 109 ++++++++++
 2 files changed

// File: rtl/data_ram.sv
// data_ram: 64x32 single-port synchronous RAM, write-first, preloaded with the [A | I] image
module data_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int DEPTH       = 64,
    parameter bit INIT_ENABLE = 1'b1
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta
);
    // Words are kept XOR-ed with the default image, so an all-zero array reads back as the image.
    function automatic logic [DATA_WIDTH-1:0] img(input logic [ADDR_WIDTH-1:0] a);
        int r;
        int c;
        r = int'(a) / 10;
        c = int'(a) % 10;
        if (!INIT_ENABLE || int'(a) >= 50) return '0;
        if (c < 5) return DATA_WIDTH'((c == r) ? 1 : (c == r + 1) ? 2 : 0);
        return DATA_WIDTH'((c - 5 == r) ? 1 : 0);
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};
    logic                  in_range;
    logic [DATA_WIDTH-1:0] base;

    assign in_range = int'(addra) < DEPTH;
    assign base     = img(addra);

    // storage: reset does not clear contents but blocks writes while asserted
    always_ff @(posedge clka) begin
        if (!rsta && wea && in_range) mem[addra] <= dina ^ base;
    end

    // registered read port, write-first, asynchronously cleared by rsta
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) douta <= '0;
        else if (wea) douta <= dina;
        else douta <= in_range ? (mem[addra] ^ base) : '0;
    end
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed vector table plus reset and streaming sequences for data_ram
module tb_data_ram;
    logic        clk = 1'b0;
    logic        rsta = 1'b1;
    logic        wea = 1'b0;
    logic [5:0]  addra = '0;
    logic [31:0] dina = '0;
    logic [31:0] douta;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_img [0:63];

    typedef struct {
        string       name;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:13];

    data_ram dut (
        .clka (clk),
        .rsta (rsta),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .douta(douta)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic cycle(input logic we, input logic [5:0] a, input logic [31:0] d);
        wea = we;
        addra = a;
        dina = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) exp_img[i] = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 10; c++)
                exp_img[r*10+c] = (c < 5) ? ((c == r) ? 32'd1 : (c == r + 1) ? 32'd2 : 32'd0)
                                          : ((c - 5 == r) ? 32'd1 : 32'd0);

        vecs[0]  = '{"img0",    1'b0, 6'd0,  32'h0,        32'd1};
        vecs[1]  = '{"img1",    1'b0, 6'd1,  32'h0,        32'd2};
        vecs[2]  = '{"img5",    1'b0, 6'd5,  32'h0,        32'd1};
        vecs[3]  = '{"img12",   1'b0, 6'd12, 32'h0,        32'd2};
        vecs[4]  = '{"img49",   1'b0, 6'd49, 32'h0,        32'd1};
        vecs[5]  = '{"img50",   1'b0, 6'd50, 32'h0,        32'd0};
        vecs[6]  = '{"img11",   1'b0, 6'd11, 32'h0,        32'd1};
        vecs[7]  = '{"img48",   1'b0, 6'd48, 32'h0,        32'd0};
        vecs[8]  = '{"wr7",     1'b1, 6'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[9]  = '{"rd7",     1'b0, 6'd7,  32'h0,        32'hDEADBEEF};
        vecs[10] = '{"rd6",     1'b0, 6'd6,  32'h0,        32'd0};
        vecs[11] = '{"wr63neg", 1'b1, 6'd63, 32'hFFFFFFF9, 32'hFFFFFFF9};
        vecs[12] = '{"rd63neg", 1'b0, 6'd63, 32'h0,        32'hFFFFFFF9};
        vecs[13] = '{"rd0",     1'b0, 6'd0,  32'h0,        32'd1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_douta", douta, 32'd0);
        rsta = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].we, vecs[i].addr, vecs[i].din);
            check(vecs[i].name, douta, vecs[i].exp);
            if (vecs[i].we) exp_img[vecs[i].addr] = vecs[i].din;
        end

        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 6'(i), 32'h0);
            check($sformatf("stream%0d", i), douta, exp_img[i]);
        end

        cycle(1'b0, 6'd1, 32'h0);
        check("pre_reset_nonzero", douta, 32'd2);
        rsta = 1'b1;
        #1;
        check("async_reset", douta, 32'd0);
        cycle(1'b1, 6'd3, 32'd5);
        check("reset_write3_douta", douta, 32'd0);
        cycle(1'b1, 6'd1, 32'd5);
        check("reset_write1_douta", douta, 32'd0);
        rsta = 1'b0;
        cycle(1'b0, 6'd3, 32'h0);
        check("collision_rd3", douta, 32'd0);
        cycle(1'b0, 6'd1, 32'h0);
        check("post_reset_rd1", douta, 32'd2);
        cycle(1'b1, 6'd50, 32'h12345678);
        cycle(1'b0, 6'd50, 32'h0);
        check("rd50_after_wr", douta, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
